clock_ratio_monitor: RTL

- Synthesizable checker for divided clocks produced by our divide-by-N clock dividers.
- Samples the divided clock as data in the source clock domain and measures period and high time in source-clock cycles.
- Declares lock once measurements repeatedly match the expected divide ratio; flags mismatch and stall.
- Used in test harnesses and clock-generation blocks to confirm divider programming at runtime.

---
 rtl/clock_ratio_monitor.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/clock_ratio_monitor.sv
// clock_ratio_monitor
// Samples a divided clock as data in the clk_in domain, measures its period
// and high time in clk_in cycles, and confirms it against an expected divide
// ratio. Reports lock, sticky mismatch (disagreement while locked) and stall
// (no rising edge within MAX_DIV cycles).
module clock_ratio_monitor #(
  parameter int MAX_DIV     = 256,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CWIDTH     = $clog2(MAX_DIV + 1)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              clk_mon,
  input  logic              enable,
  input  logic [CWIDTH-1:0] expected_div,
  output logic [CWIDTH-1:0] period,
  output logic [CWIDTH-1:0] high_cycles,
  output logic              meas_valid,
  output logic              locked,
  output logic              mismatch,
  output logic              stalled
);

  localparam logic [CWIDTH-1:0] CNT_ZERO    = CWIDTH'(0);
  localparam logic [CWIDTH-1:0] CNT_ONE     = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] MAX_CNT     = CWIDTH'(MAX_DIV);
  // ALIGN counts from 0, so MAX_DIV waiting cycles end when cnt hits MAX_DIV-1
  localparam logic [CWIDTH-1:0] ALIGN_LIMIT = CWIDTH'(MAX_DIV - 1);
  localparam logic [3:0]        LOCK_MAX    = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // Expected high time of a divide-by-div clock: the high phase takes the odd cycle
  function automatic logic [CWIDTH-1:0] high_for(input logic [CWIDTH-1:0] div);
    return div - (div >> 1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_d_r;
  logic                   s_s;
  logic                   rise_s;
  logic                   fall_s;

  state_t            state_r,      state_nxt;
  logic [CWIDTH-1:0] cnt_r,        cnt_nxt;
  logic [CWIDTH-1:0] hcnt_r,       hcnt_nxt;
  logic [CWIDTH-1:0] h_r,          h_nxt;
  logic [CWIDTH-1:0] period_r,     period_nxt;
  logic [CWIDTH-1:0] high_r,       high_nxt;
  logic              meas_valid_r, meas_valid_nxt;
  logic              locked_r,     locked_nxt;
  logic              mismatch_r,   mismatch_nxt;
  logic              stalled_r,    stalled_nxt;
  logic [3:0]        match_cnt_r,  match_cnt_nxt;
  logic              match_s;

  // Synchronize the monitored clock and keep one delayed copy for edge detection
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_r <= '0;
      s_d_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], clk_mon};
      s_d_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign s_s    = sync_r[SYNC_STAGES-1];
  assign rise_s = s_s & ~s_d_r;
  assign fall_s = ~s_s & s_d_r;

  // Next-state and next-output computation for the measurement FSM
  always_comb begin
    state_nxt      = state_r;
    cnt_nxt        = cnt_r;
    hcnt_nxt       = hcnt_r;
    h_nxt          = h_r;
    period_nxt     = period_r;
    high_nxt       = high_r;
    meas_valid_nxt = 1'b0;
    locked_nxt     = locked_r;
    mismatch_nxt   = mismatch_r;
    stalled_nxt    = stalled_r;
    match_cnt_nxt  = match_cnt_r;
    match_s        = 1'b0;

    if (!enable) begin
      state_nxt     = IDLE;
      cnt_nxt       = CNT_ZERO;
      hcnt_nxt      = CNT_ZERO;
      h_nxt         = CNT_ZERO;
      period_nxt    = CNT_ZERO;
      high_nxt      = CNT_ZERO;
      locked_nxt    = 1'b0;
      mismatch_nxt  = 1'b0;
      stalled_nxt   = 1'b0;
      match_cnt_nxt = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_nxt   = CNT_ZERO;
          hcnt_nxt  = CNT_ZERO;
          h_nxt     = CNT_ZERO;
          state_nxt = ALIGN;
        end

        ALIGN: begin
          if (rise_s) begin
            cnt_nxt     = CNT_ONE;
            hcnt_nxt    = CNT_ONE;
            stalled_nxt = 1'b0;
            state_nxt   = MEASURE;
          end else if (cnt_r >= ALIGN_LIMIT) begin
            stalled_nxt   = 1'b1;
            locked_nxt    = 1'b0;
            match_cnt_nxt = 4'd0;
            cnt_nxt       = CNT_ZERO;
          end else begin
            cnt_nxt = cnt_r + CNT_ONE;
          end
        end

        MEASURE: begin
          // A rise on the threshold cycle still publishes (period = MAX_DIV)
          if (rise_s) begin
            period_nxt     = cnt_r;
            high_nxt       = h_r;
            meas_valid_nxt = 1'b1;
            cnt_nxt        = CNT_ONE;
            hcnt_nxt       = CNT_ONE;
            stalled_nxt    = 1'b0;
            match_s        = (cnt_r == expected_div) && (h_r == high_for(expected_div));
            if (match_s) begin
              if (match_cnt_r < LOCK_MAX) begin
                match_cnt_nxt = match_cnt_r + 4'd1;
              end else begin
                match_cnt_nxt = match_cnt_r;
              end
              locked_nxt = (match_cnt_nxt == LOCK_MAX);
            end else begin
              match_cnt_nxt = 4'd0;
              locked_nxt    = 1'b0;
              if (locked_r) begin
                mismatch_nxt = 1'b1;
              end else begin
                mismatch_nxt = mismatch_r;
              end
            end
          end else if (cnt_r >= MAX_CNT) begin
            stalled_nxt   = 1'b1;
            locked_nxt    = 1'b0;
            match_cnt_nxt = 4'd0;
            cnt_nxt       = CNT_ZERO;
            hcnt_nxt      = CNT_ZERO;
            state_nxt     = ALIGN;
          end else begin
            cnt_nxt = cnt_r + CNT_ONE;
            if (s_s) begin
              hcnt_nxt = hcnt_r + CNT_ONE;
            end else begin
              hcnt_nxt = hcnt_r;
            end
            if (fall_s) begin
              h_nxt = hcnt_r;
            end else begin
              h_nxt = h_r;
            end
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      hcnt_r       <= CNT_ZERO;
      h_r          <= CNT_ZERO;
      period_r     <= CNT_ZERO;
      high_r       <= CNT_ZERO;
      meas_valid_r <= 1'b0;
      locked_r     <= 1'b0;
      mismatch_r   <= 1'b0;
      stalled_r    <= 1'b0;
      match_cnt_r  <= 4'd0;
    end else begin
      state_r      <= state_nxt;
      cnt_r        <= cnt_nxt;
      hcnt_r       <= hcnt_nxt;
      h_r          <= h_nxt;
      period_r     <= period_nxt;
      high_r       <= high_nxt;
      meas_valid_r <= meas_valid_nxt;
      locked_r     <= locked_nxt;
      mismatch_r   <= mismatch_nxt;
      stalled_r    <= stalled_nxt;
      match_cnt_r  <= match_cnt_nxt;
    end
  end

  assign period      = period_r;
  assign high_cycles = high_r;
  assign meas_valid  = meas_valid_r;
  assign locked      = locked_r;
  assign mismatch    = mismatch_r;
  assign stalled     = stalled_r;

endmodule
